// File: rtl/instr_load_pkg.sv
// Shared types and constants for the instruction loader.
package instr_load_pkg;

    // Loader control states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        WRITE  = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_e;

    localparam int BYTES_PER_WORD    = 4;
    localparam int DEFAULT_MEM_BYTES = 2048;

    // Most significant byte of a word; the byte stream is big-endian.
    function automatic logic [7:0] msb_byte(input logic [31:0] word);
        return word[31:24];
    endfunction

endpackage

// File: rtl/word_to_byte_serializer.sv
// Holds one instruction word and walks it out MSB-first, one byte per step,
// advancing the byte address with every step.
module word_to_byte_serializer
    import instr_load_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [31:0]       word_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic [7:0]        byte_o,
    output logic [1:0]        idx_o
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [31:0]       shift_q, shift_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Next-state: restart rewinds the address, load captures a word, step emits a byte.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        if (restart_i) begin
            addr_d = BASE;
        end else if (load_i) begin
            shift_d = word_i;
            idx_d   = 2'd0;
        end else if (step_i) begin
            shift_d = {shift_q[23:0], 8'h00};
            idx_d   = idx_q + 2'd1;
            addr_d  = addr_q + ADDR_ONE;
        end else begin
            shift_d = shift_q;
            idx_d   = idx_q;
            addr_d  = addr_q;
        end
    end

    // Serializer state registers; reset parks the address at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= 32'h0000_0000;
            idx_q   <= 2'd0;
            addr_q  <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
        end
    end

    assign addr_o      = addr_q;
    assign next_addr_o = addr_q + ADDR_ONE;
    assign byte_o      = msb_byte(shift_q);
    assign idx_o       = idx_q;

endmodule

// File: rtl/instruction_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory,
// MSB at the lowest address, while holding the CPU off until the image is in.
module instruction_loader
    import instr_load_pkg::*;
#(
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
    parameter int ADDR_W    = 32,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       in_data_i,
    input  logic              in_last_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W-3:0] word_count_o
);

    // Highest address at which a whole word still fits in memory.
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_BYTES - BYTES_PER_WORD);
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
    localparam logic              BASE_FITS  = (BASE <= ADDR_LIMIT) ? 1'b1 : 1'b0;
    localparam logic [ADDR_W-3:0] WC_ONE     = (ADDR_W-2)'(1);

    state_e            state_q;
    logic              in_ready_q;
    logic              mem_we_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              error_q;
    logic              last_q;
    logic [ADDR_W-3:0] word_count_q;

    logic              restart_s;
    logic              load_s;
    logic              step_s;
    logic              overflow_s;
    logic              next_fits_s;
    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic [1:0]        idx_s;

    // start is honoured only when no load is in progress.
    assign restart_s   = start_i && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
    assign overflow_s  = (addr_s > ADDR_LIMIT);
    assign next_fits_s = (next_addr_s <= ADDR_LIMIT);
    assign load_s      = (state_q == ACCEPT) && in_valid_i && in_ready_q && !overflow_s;
    assign step_s      = (state_q == WRITE);

    word_to_byte_serializer #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .restart_i   (restart_s),
        .load_i      (load_s),
        .step_i      (step_s),
        .word_i      (in_data_i),
        .addr_o      (addr_s),
        .next_addr_o (next_addr_s),
        .byte_o      (mem_wdata_o),
        .idx_o       (idx_s)
    );

    // Load control FSM; every status output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            last_q       <= 1'b0;
            word_count_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (restart_s) begin
                        state_q      <= ACCEPT;
                        in_ready_q   <= BASE_FITS;
                        cpu_hold_q   <= 1'b1;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        word_count_q <= '0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                ACCEPT: begin
                    if (overflow_s) begin
                        // Refuse the word before any of its bytes can land past the end.
                        state_q    <= ERR;
                        in_ready_q <= 1'b0;
                        error_q    <= 1'b1;
                        cpu_hold_q <= 1'b1;
                    end else if (load_s) begin
                        state_q    <= WRITE;
                        in_ready_q <= 1'b0;
                        mem_we_q   <= 1'b1;
                        last_q     <= in_last_i;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                WRITE: begin
                    if (idx_s == 2'd3) begin
                        mem_we_q     <= 1'b0;
                        word_count_q <= word_count_q + WC_ONE;
                        if (last_q) begin
                            state_q    <= DONE;
                            in_ready_q <= 1'b0;
                            cpu_hold_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            state_q    <= ACCEPT;
                            in_ready_q <= next_fits_s;
                        end
                    end else begin
                        mem_we_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    mem_we_q   <= 1'b0;
                    cpu_hold_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o   = in_ready_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = addr_s;
    assign cpu_hold_o   = cpu_hold_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign word_count_o = word_count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader with a write scoreboard.
module tb_instruction_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    // main instance (2048 bytes)
    logic        start, in_valid, in_last, in_ready, mem_we, cpu_hold, done, error;
    logic [31:0] in_data, mem_addr;
    logic [7:0]  mem_wdata;
    logic [29:0] word_count;
    // small instance (8 bytes) for overflow
    logic        s_start, s_valid, s_last, s_ready, s_we, s_hold, s_done, s_error;
    logic [31:0] s_data, s_addr;
    logic [7:0]  s_wdata;
    logic [29:0] s_wc;

    wr_t         exp_q[$];
    wr_t         s_exp_q[$];
    logic [31:0] exp_addr;
    logic [31:0] s_exp_addr;
    int          checks = 0;
    int          errors = 0;
    int          writes = 0;
    int          s_writes = 0;

    always #5 clk = ~clk;

    instruction_loader dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .cpu_hold_o(cpu_hold), .done_o(done), .error_o(error), .word_count_o(word_count)
    );

    instruction_loader #(.MEM_BYTES(8)) dut_small (
        .clk(clk), .rst_n(rst_n), .start_i(s_start), .in_valid_i(s_valid),
        .in_ready_o(s_ready), .in_data_i(s_data), .in_last_i(s_last),
        .mem_we_o(s_we), .mem_addr_o(s_addr), .mem_wdata_o(s_wdata),
        .cpu_hold_o(s_hold), .done_o(s_done), .error_o(s_error), .word_count_o(s_wc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_word(ref wr_t q[$], input logic [31:0] base, input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            wr_t e;
            e.addr = base + 32'(b);
            e.data = w[31-8*b -: 8];
            q.push_back(e);
        end
    endfunction

    // Main-instance scoreboard: every observed write must match the oldest expectation.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_t e;
            writes++;
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    end

    // Small-instance scoreboard.
    always @(negedge clk) begin
        if (s_we) begin
            wr_t e;
            s_writes++;
            check("s_write_expected", 64'(s_exp_q.size() != 0), 64'd1);
            if (s_exp_q.size() != 0) begin
                e = s_exp_q.pop_front();
                check("s_wr_addr", 64'(s_addr), 64'(e.addr));
                check("s_wr_data", 64'(s_wdata), 64'(e.data));
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        exp_addr = 32'd0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk); n++;
        end
        check("send_ready_timeout", 64'(n < 40), 64'd1);
        push_word(exp_q, exp_addr, d);
        exp_addr = exp_addr + 32'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic s_send(input logic [31:0] d);
        int n;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = 1'b0;
        n = 0;
        while (!s_ready && n < 40) begin
            @(negedge clk); n++;
        end
        check("s_send_ready_timeout", 64'(n < 40), 64'd1);
        push_word(s_exp_q, s_exp_addr, d);
        s_exp_addr = s_exp_addr + 32'd4;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk); n++;
        end
        check("done_timeout", 64'(n < 40), 64'd1);
    endtask

    initial begin
        int wr_before;
        int seen_ready;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 32'd0;
        s_start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 32'd0;
        exp_addr = 32'd0; s_exp_addr = 32'd0;

        // ---- reset state
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_mem_we",   64'(mem_we),   64'd0);
        check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
        check("rst_done",     64'(done),     64'd0);
        check("rst_error",    64'(error),    64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd0);

        // ---- single word
        pulse_start();
        check("single_hold_on", 64'(cpu_hold), 64'd1);
        check("single_ready",   64'(in_ready), 64'd1);
        send_word(32'hE3A0_1005, 1'b1);
        wait_done();
        check("single_done",     64'(done),         64'd1);
        check("single_wc",       64'(word_count),   64'd1);
        check("single_hold_off", 64'(cpu_hold),     64'd0);
        check("single_writes",   64'(writes),       64'd4);
        check("single_drained",  64'(exp_q.size()), 64'd0);

        // ---- backpressure, start during WRITE ignored
        pulse_start();
        check("restart_done_clr", 64'(done),       64'd0);
        check("restart_wc_clr",   64'(word_count), 64'd0);
        check("bp_ready_initial", 64'(in_ready),   64'd1);
        in_valid = 1'b1; in_data = 32'h1234_5678; in_last = 1'b0;
        push_word(exp_q, 32'd0, 32'h1234_5678);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_ready_low", 64'(in_ready), 64'd0);
            check("bp_we_high",   64'(mem_we),   64'd1);
            if (k == 1) start = 1'b1;
            if (k == 2) start = 1'b0;
        end
        @(negedge clk);
        check("bp_ready_n5", 64'(in_ready), 64'd1);
        in_data = 32'hCAFE_F00D; in_last = 1'b1;
        push_word(exp_q, 32'd4, 32'hCAFE_F00D);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done();
        check("bp_wc",      64'(word_count),   64'd2);
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        check("bp_writes",  64'(writes),       64'd12);

        // ---- reset in the middle of a word
        pulse_start();
        send_word(32'hA1B2_C3D4, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we",    64'(mem_we),   64'd0);
        check("mid_rst_hold",  64'(cpu_hold), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd0);
        check("mid_rst_addr",  64'(mem_addr), 64'd0);
        check("mid_rst_partial", 64'(exp_q.size()), 64'd2);
        exp_q.delete();
        wr_before = writes;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_no_writes", 64'(writes), 64'(wr_before));
        check("post_rst_idle_ready", 64'(in_ready), 64'd0);
        pulse_start();
        send_word(32'h0BAD_BEEF, 1'b1);
        wait_done();
        check("reload_wc",      64'(word_count),   64'd1);
        check("reload_drained", 64'(exp_q.size()), 64'd0);

        // ---- overflow on an 8-byte memory
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        s_send(32'h1122_3344);
        s_send(32'h5566_7788);
        @(negedge clk);
        s_valid = 1'b1; s_data = 32'h99AA_BBCC;
        seen_ready = 0;
        repeat (20) begin
            @(negedge clk);
            if (s_ready) seen_ready++;
        end
        s_valid = 1'b0;
        check("ovf_never_ready", 64'(seen_ready), 64'd0);
        check("ovf_error",   64'(s_error),        64'd1);
        check("ovf_wc",      64'(s_wc),           64'd2);
        check("ovf_hold",    64'(s_hold),         64'd1);
        check("ovf_done",    64'(s_done),         64'd0);
        check("ovf_writes",  64'(s_writes),       64'd8);
        check("ovf_drained", 64'(s_exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
